// File: rtl/acs_array.sv
// Parametrised add-compare-select array for a rate-1/2 Viterbi decoder.
// One trellis step per bm_valid, renormalised metrics, lowest-index best state.
module acs_array #(
  parameter int       K           = 3,
  parameter logic [K-1:0] G0      = 3'b111,
  parameter logic [K-1:0] G1      = 3'b101,
  parameter int       BMW         = 2,
  parameter int       MW          = 6,
  parameter int       BLK_LEN     = 8,
  parameter bit       START_KNOWN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         bm_valid,
  input  logic [4*BMW-1:0]             bm,
  output logic                         dec_valid,
  output logic [(1<<(K-1))-1:0]        dec_bits,
  output logic [K-2:0]                 best_state,
  output logic [MW-1:0]                best_metric,
  output logic                         norm_evt,
  output logic [$clog2(BLK_LEN)-1:0]   step_cnt,
  output logic                         blk_done
);

  localparam int NS = 1 << (K - 1);
  localparam int SW = K - 1;
  localparam int CW = $clog2(BLK_LEN);
  localparam logic [MW:0]   HALF = {2'b01, {(MW-1){1'b0}}};
  localparam logic [MW-1:0] QTR  = {2'b01, {(MW-2){1'b0}}};

  function automatic logic [MW-1:0] init_pm(input int s);
    if (s == 0 || !START_KNOWN) return '0;
    return QTR;
  endfunction

  function automatic logic [SW-1:0] pred(input int s, input logic x);
    logic [SW-1:0] sp;
    sp = SW'(s);
    return {sp[SW-2:0], x};
  endfunction

  function automatic logic ubit(input int s);
    logic [SW-1:0] sp;
    sp = SW'(s);
    return sp[SW-1];
  endfunction

  function automatic logic [MW:0] bm_of(
    input logic [4*BMW-1:0] b,
    input logic [K-1:0]     r
  );
    logic [1:0] cw;
    cw = {^(G0 & r), ^(G1 & r)};
    return (MW+1)'(b[cw*BMW +: BMW]);
  endfunction

  logic [MW-1:0] pm_q   [NS];
  logic [MW-1:0] pm_d   [NS];
  logic [MW-1:0] base   [NS];
  logic [MW:0]   cand0  [NS];
  logic [MW:0]   cand1  [NS];
  logic [MW:0]   newm   [NS];
  logic [NS-1:0] dec_w;
  logic [MW:0]   min_v;
  logic [SW-1:0] min_s;
  logic          norm;
  logic [MW:0]   sub;
  logic [CW-1:0] step_base;
  logic          wrap;

  logic          dv_q,   dv_d;
  logic [NS-1:0] db_q,   db_d;
  logic [SW-1:0] bs_q,   bs_d;
  logic [MW-1:0] bmet_q, bmet_d;
  logic          ne_q,   ne_d;
  logic [CW-1:0] step_q, step_d;
  logic          blk_q,  blk_d;

  always_comb begin
    // start re-seeds the metrics used by a same-cycle step
    for (int s = 0; s < NS; s++) begin
      base[s] = start ? init_pm(s) : pm_q[s];
    end
    for (int s = 0; s < NS; s++) begin
      cand0[s] = {1'b0, base[pred(s, 1'b0)]}
               + bm_of(bm, {ubit(s), pred(s, 1'b0)});
      cand1[s] = {1'b0, base[pred(s, 1'b1)]}
               + bm_of(bm, {ubit(s), pred(s, 1'b1)});
      dec_w[s] = cand1[s] < cand0[s];
      newm[s]  = dec_w[s] ? cand1[s] : cand0[s];
    end
    min_v = newm[0];
    min_s = '0;
    for (int s = 1; s < NS; s++) begin
      if (newm[s] < min_v) begin
        min_v = newm[s];
        min_s = SW'(s);
      end
    end
    norm = min_v >= HALF;
    sub  = norm ? HALF : '0;
    for (int s = 0; s < NS; s++) begin
      pm_d[s] = bm_valid ? MW'(newm[s] - sub) : base[s];
    end
    step_base = start ? '0 : step_q;
    wrap      = step_base == CW'(BLK_LEN - 1);
    step_d    = step_base;
    if (bm_valid) step_d = wrap ? '0 : step_base + CW'(1);
    dv_d   = bm_valid;
    ne_d   = bm_valid & norm;
    blk_d  = bm_valid & wrap;
    db_d   = bm_valid ? dec_w : db_q;
    bs_d   = bm_valid ? min_s : bs_q;
    bmet_d = bm_valid ? MW'(min_v - sub) : bmet_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < NS; s++) pm_q[s] <= init_pm(s);
      step_q <= '0;
      dv_q   <= 1'b0;
      db_q   <= '0;
      bs_q   <= '0;
      bmet_q <= '0;
      ne_q   <= 1'b0;
      blk_q  <= 1'b0;
    end else begin
      for (int s = 0; s < NS; s++) pm_q[s] <= pm_d[s];
      step_q <= step_d;
      dv_q   <= dv_d;
      db_q   <= db_d;
      bs_q   <= bs_d;
      bmet_q <= bmet_d;
      ne_q   <= ne_d;
      blk_q  <= blk_d;
    end
  end

  assign dec_valid   = dv_q;
  assign dec_bits    = db_q;
  assign best_state  = bs_q;
  assign best_metric = bmet_q;
  assign norm_evt    = ne_q;
  assign step_cnt    = step_q;
  assign blk_done    = blk_q;

endmodule

// File: tb/tb_acs_array.sv
// Bench for acs_array at default parameters.
// Per-cycle expected outputs come from a trellis reference model via a queue.
module tb_acs_array;

  localparam int NS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       bm_valid = 1'b0;
  logic [7:0] bm = '0;
  logic       dec_valid;
  logic [3:0] dec_bits;
  logic [1:0] best_state;
  logic [5:0] best_metric;
  logic       norm_evt;
  logic [2:0] step_cnt;
  logic       blk_done;

  acs_array dut (
    .clk(clk), .rst(rst), .start(start), .bm_valid(bm_valid), .bm(bm),
    .dec_valid(dec_valid), .dec_bits(dec_bits), .best_state(best_state),
    .best_metric(best_metric), .norm_evt(norm_evt), .step_cnt(step_cnt),
    .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  typedef logic [17:0] vec_t;
  vec_t sb[$];
  vec_t obs, exp_v, first_v;
  vec_t m_out = '0;
  int   m_pm[NS];
  int   m_step;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t out_now();
    return {dec_valid, dec_bits, best_state, best_metric,
            norm_evt, step_cnt, blk_done};
  endfunction

  task automatic m_init();
    for (int i = 0; i < NS; i++) m_pm[i] = (i == 0) ? 0 : 16;
    m_step = 0;
  endtask

  task automatic apply(input logic st, input logic v, input logic [7:0] b);
    int nm[NS];
    int c[2];
    int p, cw, mn, ms;
    logic [3:0] db;
    logic [2:0] rv;
    logic nrm, blk;
    start = st;
    bm_valid = v;
    bm = b;
    if (st) m_init();
    if (v) begin
      for (int sp = 0; sp < NS; sp++) begin
        for (int x = 0; x < 2; x++) begin
          p  = ((sp & 1) << 1) | x;
          rv = 3'(((sp >> 1) << 2) | p);
          cw = 2 * int'(^(rv & 3'b111)) + int'(^(rv & 3'b101));
          c[x] = m_pm[p] + int'((b >> (2 * cw)) & 8'h3);
        end
        db[sp] = c[1] < c[0];
        nm[sp] = (c[1] < c[0]) ? c[1] : c[0];
      end
      mn = nm[0];
      ms = 0;
      for (int sp = 1; sp < NS; sp++)
        if (nm[sp] < mn) begin mn = nm[sp]; ms = sp; end
      nrm = mn >= 32;
      if (nrm) begin
        for (int sp = 0; sp < NS; sp++) nm[sp] -= 32;
        mn -= 32;
      end
      for (int sp = 0; sp < NS; sp++) m_pm[sp] = nm[sp];
      blk = m_step == 7;
      m_step = blk ? 0 : m_step + 1;
      m_out = {1'b1, db, 2'(ms), 6'(mn), nrm, 3'(m_step), blk};
    end else begin
      m_out = {1'b0, m_out[16:5], 1'b0, 3'(m_step), 1'b0};
    end
    sb.push_back(m_out);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_init();
    m_out = '0;
    #1;
    obs = out_now();
    n_vec++;
    if (obs !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_out got %h want %h", obs, 18'h0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    apply(1'b0, 1'b0, 8'hff);
    @(negedge clk);
    obs = out_now(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL reset_idle got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_first_step();
    apply(1'b1, 1'b1, 8'h94);
    @(negedge clk);
    obs = out_now(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL first_step got %h want %h", obs, exp_v);
    end
    first_v = obs;
    n_vec++;
    if ({dec_valid, best_state, best_metric, step_cnt} !== {1'b1, 2'd0, 6'd0, 3'd1}) begin
      n_bad++;
      $display("FAIL first_fields got %b/%0d/%0d/%0d want 1/0/0/1",
               dec_valid, best_state, best_metric, step_cnt);
    end
    n_vec++;
    if (dec_bits[1] !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_state01 got %b want 0", dec_bits[1]);
    end
    apply(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    obs = out_now(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL first_hold got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_tie_break();
    apply(1'b1, 1'b1, 8'h84);
    @(negedge clk);
    obs = out_now(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL tie_step got %h want %h", obs, exp_v);
    end
    n_vec++;
    if (dec_bits[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL odd_pred_state11 got %b want 1", dec_bits[3]);
    end
  endtask

  task automatic test_normalise();
    for (int i = 0; i < 12; i++) begin
      apply(i == 0, i < 11, 8'hff);
      @(negedge clk);
      obs = out_now(); exp_v = sb.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL norm_step%0d got %h want %h", i, obs, exp_v);
      end
      n_vec++;
      if (norm_evt !== (i == 10)) begin
        n_bad++;
        $display("FAIL norm_evt%0d got %b want %b", i, norm_evt, i == 10);
      end
    end
    n_vec++;
    if (best_metric !== 6'd1) begin
      n_bad++;
      $display("FAIL norm_metric got %0d want 1", best_metric);
    end
  endtask

  task automatic test_block_counter();
    for (int i = 0; i < 9; i++) begin
      apply(i == 0, 1'b1, 8'($urandom_range(0, 255)));
      @(negedge clk);
      obs = out_now(); exp_v = sb.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL blk_step%0d got %h want %h", i, obs, exp_v);
      end
      if (i >= 7) begin
        n_vec++;
        if ({blk_done, step_cnt} !== ((i == 7) ? 4'b1_000 : 4'b0_001)) begin
          n_bad++;
          $display("FAIL blk_wrap%0d got %b/%0d want %b", i, blk_done,
                   step_cnt, i == 7);
        end
      end
    end
    apply(1'b1, 1'b1, 8'($urandom_range(0, 255)));
    @(negedge clk);
    obs = out_now(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v || step_cnt !== 3'd1) begin
      n_bad++;
      $display("FAIL restart got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, (i % 2) == 0, 8'($urandom_range(0, 255)));
      @(negedge clk);
      obs = out_now(); exp_v = sb.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL gap%0d got %h want %h", i, obs, exp_v);
      end
    end
    apply(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    obs = out_now(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL start_alone got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      apply(i == 0, 1'b1, 8'($urandom_range(0, 255)));
      @(negedge clk);
      obs = out_now(); exp_v = sb.pop_front(); n_vec++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL mid_step%0d got %h want %h", i, obs, exp_v);
      end
    end
    start = 1'b0;
    bm_valid = 1'b0;
    #2 rst = 1'b0;
    m_init();
    m_out = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) #1;
      else @(negedge clk);
      obs = out_now(); n_vec++;
      if (obs !== 18'h0) begin
        n_bad++;
        $display("FAIL mid_reset%0d got %h want 0", i, obs);
      end
    end
    rst = 1'b1;
    apply(1'b0, 1'b1, 8'h94);
    @(negedge clk);
    obs = out_now(); exp_v = sb.pop_front(); n_vec++;
    if (obs !== exp_v || obs !== first_v) begin
      n_bad++;
      $display("FAIL post_reset got %h want %h", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_first_step();
    test_tie_break();
    test_normalise();
    test_block_counter();
    test_gapped();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
